// File: rtl/input_port_buffer_pkg.sv
// Shared constants for the mesh router input port: address and direction widths,
// direction codes, FSM states and flit field offsets.
package input_port_buffer_pkg;

   localparam int ADDR_SZ  = 4;   // 3x3 mesh, node = row*3 + col
   localparam int BITS_DIR = 3;

   typedef enum logic [BITS_DIR-1:0] {
      DIR_LOCAL = 3'd0,
      DIR_EAST  = 3'd1,
      DIR_WEST  = 3'd2,
      DIR_SOUTH = 3'd3,
      DIR_NORTH = 3'd4
   } dir_e;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ROUTE = 2'd1,
      ST_REQ   = 2'd2,
      ST_XFER  = 2'd3
   } ipb_state_e;

   // Flit layout: {is_head, is_tail, dest[ADDR_SZ-1:0], payload[PAYLOAD_W-1:0]}
   function automatic int flit_w(input int payload_w);
      return 2 + ADDR_SZ + payload_w;
   endfunction

   function automatic int flit_head_bit(input int payload_w);
      return payload_w + ADDR_SZ + 1;
   endfunction

   function automatic int flit_tail_bit(input int payload_w);
      return payload_w + ADDR_SZ;
   endfunction

   function automatic int flit_dest_lsb(input int payload_w);
      return payload_w;
   endfunction

endpackage

// File: rtl/input_port_buffer_if.sv
// Upstream link, routing-table, allocator and crossbar signals of one router input port.
// With IPB_CREDIT_EN defined, in_ready is replaced by a credit_out pulse per FIFO pop.
interface input_port_buffer_if
   import input_port_buffer_pkg::*;
#(
   parameter int PAYLOAD_W = 16
);
   localparam int FLIT_W = flit_w(PAYLOAD_W);

   logic [FLIT_W-1:0]   in_flit;
   logic                in_valid;
`ifdef IPB_CREDIT_EN
   logic                credit_out;
`else
   logic                in_ready;
`endif
   logic [ADDR_SZ-1:0]  table_addr;
   logic [BITS_DIR-1:0] table_data;
   logic                req_valid;
   logic [BITS_DIR-1:0] req_dir;
   logic                grant;
   logic [FLIT_W-1:0]   out_flit;
   logic                out_valid;
   logic                out_ready;
   logic                release_o;
   logic                err_drop;

`ifdef IPB_CREDIT_EN
   modport slave (
      input  in_flit, in_valid, table_data, grant, out_ready,
      output credit_out, table_addr, req_valid, req_dir, out_flit, out_valid, release_o, err_drop
   );
   modport master (
      output in_flit, in_valid, table_data, grant, out_ready,
      input  credit_out, table_addr, req_valid, req_dir, out_flit, out_valid, release_o, err_drop
   );
`else
   modport slave (
      input  in_flit, in_valid, table_data, grant, out_ready,
      output in_ready, table_addr, req_valid, req_dir, out_flit, out_valid, release_o, err_drop
   );
   modport master (
      output in_flit, in_valid, table_data, grant, out_ready,
      input  in_ready, table_addr, req_valid, req_dir, out_flit, out_valid, release_o, err_drop
   );
`endif

endinterface

// File: rtl/input_port_buffer_flit_fifo.sv
// Registered flit FIFO (no fall-through); head is the oldest stored entry.
// DEPTH must be a power of two so the pointers wrap by plain overflow.
module flit_fifo #(
   parameter int DEPTH  = 4,
   parameter int FLIT_W = 22
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_push,
   input  logic              i_pop,
   input  logic [FLIT_W-1:0] i_data,
   output logic [FLIT_W-1:0] o_head,
   output logic              o_full,
   output logic              o_empty
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [FLIT_W-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0]  r_wr_ptr;
   logic [PTR_W-1:0]  r_rd_ptr;
   logic [CNT_W-1:0]  r_count;
   logic              w_do_push;
   logic              w_do_pop;

   assign o_full    = (r_count == CNT_W'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign w_do_push = i_push && !o_full;
   assign w_do_pop  = i_pop && !o_empty;
   assign o_head    = r_mem[r_rd_ptr];

   // NOTE: the storage array is left unreset; r_count alone says which entries are valid.
   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_data;
   end

   // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/input_port_buffer.sv
// Router input port: buffers flits, looks up the head's route, requests the output
// port and streams the packet to the crossbar. IPB_CREDIT_EN selects credit flow control.
module input_port_buffer
   import input_port_buffer_pkg::*;
#(
   parameter int DEPTH     = 4,
   parameter int PAYLOAD_W = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [ADDR_SZ-1:0] id,
   input_port_buffer_if.slave bus
);
   localparam int FLIT_W        = flit_w(PAYLOAD_W);
   localparam int FLIT_HEAD_BIT = flit_head_bit(PAYLOAD_W);
   localparam int FLIT_TAIL_BIT = flit_tail_bit(PAYLOAD_W);
   localparam int FLIT_DEST_LSB = flit_dest_lsb(PAYLOAD_W);

   ipb_state_e         r_state;
   dir_e               r_route;
   logic               r_req_valid;
   logic [FLIT_W-1:0]  w_head;
   logic [ADDR_SZ-1:0] w_dest;
   logic               w_full;
   logic               w_empty;
   logic               w_drop;
   logic               w_xfer;
   logic               w_pop;
   logic               w_out_valid;

   flit_fifo #(
      .DEPTH  (DEPTH),
      .FLIT_W (FLIT_W)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (bus.in_valid),
      .i_pop   (w_pop),
      .i_data  (bus.in_flit),
      .o_head  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   assign w_dest = w_head[FLIT_DEST_LSB +: ADDR_SZ];

   // NOTE: every signal gets a default first so no path through the block infers a latch.
   always_comb begin
      w_out_valid = 1'b0;
      w_drop      = 1'b0;
      w_xfer      = 1'b0;
      if (!w_empty) begin
         w_drop      = (r_state == ST_IDLE) && !w_head[FLIT_HEAD_BIT];
         w_out_valid = (r_state == ST_XFER);
         w_xfer      = (r_state == ST_XFER) && bus.out_ready;
      end
   end

   assign w_pop = w_drop || w_xfer;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_route     <= DIR_LOCAL;
         r_req_valid <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (!w_empty && w_head[FLIT_HEAD_BIT]) r_state <= ST_ROUTE;
            end
            ST_ROUTE: begin
               r_route     <= dir_e'(bus.table_data);
               r_req_valid <= 1'b1;
               r_state     <= ST_REQ;
            end
            ST_REQ: begin
               if (bus.grant) begin
                  r_req_valid <= 1'b0;
                  r_state     <= ST_XFER;
               end
            end
            ST_XFER: begin
               if (w_xfer && w_head[FLIT_TAIL_BIT]) r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.table_addr = w_empty ? '0 : w_dest;
   assign bus.req_valid  = r_req_valid;
   assign bus.req_dir    = r_req_valid ? r_route : DIR_LOCAL;
   assign bus.out_valid  = w_out_valid;
   assign bus.out_flit   = w_out_valid ? w_head : '0;
   assign bus.release_o  = w_xfer && w_head[FLIT_TAIL_BIT];
   assign bus.err_drop   = w_drop;

`ifdef IPB_CREDIT_EN
   logic r_credit_out;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_credit_out <= 1'b0;
      else        r_credit_out <= w_pop;
   end

   assign bus.credit_out = r_credit_out;

   // Upstream must never spend a credit it does not hold; such a flit is dropped by the FIFO.
   a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
      bus.in_valid |-> !w_full);
`else
   assign bus.in_ready = !w_full;
`endif

   // A head addressed to this node must come back from the table as LOCAL.
   a_self_routes_local: assert property (@(posedge clk) disable iff (!rst_n)
      (r_state == ST_ROUTE && w_dest == id) |-> (bus.table_data == BITS_DIR'(DIR_LOCAL)));

endmodule

// File: tb/tb_input_port_buffer.sv
// Scoreboard bench for input_port_buffer (ready/valid build): directed latency, backpressure,
// drop and reset cases, then randomized packet traffic against a packet-level model.
module tb_input_port_buffer;
   import input_port_buffer_pkg::*;

   localparam int DEPTH     = 4;
   localparam int PAYLOAD_W = 16;
   localparam int FLIT_W    = 2 + ADDR_SZ + PAYLOAD_W;
   localparam int HB        = FLIT_W - 1;
   localparam int TB        = FLIT_W - 2;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic [ADDR_SZ-1:0] id = 4'd4;

   input_port_buffer_if #(.PAYLOAD_W(PAYLOAD_W)) bus ();

   input_port_buffer #(
      .DEPTH     (DEPTH),
      .PAYLOAD_W (PAYLOAD_W)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .id    (id),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [FLIT_W-1:0] flit;
      bit                drop;
   } exp_t;

   exp_t                exp_q [$];
   logic [BITS_DIR-1:0] dir_q [$];
   bit                  in_pkt;
   int                  n_tests = 0;
   int                  n_fail  = 0;
   bit                  auto_grant = 0;
   bit                  force_grant = 0;
   bit                  rand_ready = 0;
   bit                  ready_cmd = 1;
   int                  gdelay = 0;

   // XY dimension-order routing on the 3x3 mesh, column first; north is row 0.
   function automatic logic [BITS_DIR-1:0] xy_route(input int cur, input int dst);
      int cx = cur % 3;
      int cy = cur / 3;
      int dx = dst % 3;
      int dy = dst / 3;
      if (dx > cx) return DIR_EAST;
      if (dx < cx) return DIR_WEST;
      if (dy > cy) return DIR_SOUTH;
      if (dy < cy) return DIR_NORTH;
      return DIR_LOCAL;
   endfunction

   assign bus.table_data = xy_route(int'(id), int'(bus.table_addr));

   function automatic logic [FLIT_W-1:0] mk_flit(input bit h, input bit t, input int dest,
                                                 input logic [15:0] pl);
      logic [ADDR_SZ-1:0] d = ADDR_SZ'(dest);
      return {h, t, d, pl};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Packet-level model: a flit outside a packet that is not a head is discarded.
   task automatic model_accept(input logic [FLIT_W-1:0] f);
      if (!in_pkt) begin
         if (f[HB]) begin
            exp_q.push_back('{flit: f, drop: 1'b0});
            dir_q.push_back(xy_route(int'(id), int'(f[PAYLOAD_W +: ADDR_SZ])));
            in_pkt = !f[TB];
         end else begin
            exp_q.push_back('{flit: f, drop: 1'b1});
         end
      end else begin
         exp_q.push_back('{flit: f, drop: 1'b0});
         if (f[TB]) in_pkt = 0;
      end
   endtask

   // Monitor: every FIFO pop is matched against the oldest expected entry.
   always @(negedge clk) begin
      bit   xfer;
      exp_t e;
      if (rst_n) begin
         check("in_ready_vs_occupancy", bus.in_ready, exp_q.size() < DEPTH);
         xfer = bus.out_valid && bus.out_ready;
         check("drop_xfer_exclusive", bus.err_drop && xfer, 0);
         if (bus.err_drop || xfer) begin
            check("pop_model_nonempty", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               if (bus.err_drop) begin
                  check("err_drop_expected", e.drop, 1);
               end else begin
                  check("xfer_expected", e.drop, 0);
                  check("out_flit", bus.out_flit, e.flit);
                  check("release_with_tail", bus.release_o, e.flit[TB]);
               end
            end
         end else begin
            check("release_without_xfer", bus.release_o, 0);
         end
         if (bus.req_valid) begin
            check("req_has_pending_head", dir_q.size() != 0, 1);
            if (dir_q.size() != 0) begin
               check("req_dir", bus.req_dir, dir_q[0]);
               if (bus.grant) void'(dir_q.pop_front());
            end
         end
         if (bus.in_valid && bus.in_ready) model_accept(bus.in_flit);
      end
   end

   // Single driver for grant and out_ready, a little after each rising edge.
   initial begin
      forever begin
         @(posedge clk);
         #2;
         if (auto_grant) begin
            if (bus.req_valid) begin
               if (gdelay == 0) begin
                  bus.grant = 1'b1;
                  gdelay    = $urandom_range(0, 3);
               end else begin
                  bus.grant = 1'b0;
                  gdelay--;
               end
            end else begin
               bus.grant = ($urandom_range(0, 7) == 0);  // stray grants must be ignored
            end
         end else begin
            bus.grant = force_grant;
         end
         bus.out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_cmd;
      end
   end

   task automatic offer(input logic [FLIT_W-1:0] f);
      int waited = 0;
      bit done = 0;
      bus.in_valid = 1'b1;
      bus.in_flit  = f;
      while (!done) begin
         @(negedge clk);
         if (bus.in_ready) begin
            done = 1;
         end else if (waited++ > 200) begin
            check("offer_accept_timeout", bus.in_ready, 1);
            done = 1;
         end
         tick();
      end
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_req(input int max_cycles);
      int i = 0;
      while (!bus.req_valid && i < max_cycles) begin
         tick();
         i++;
      end
      check("wait_req_valid", bus.req_valid, 1);
   endtask

   task automatic wait_drain(input int max_cycles);
      int i = 0;
      while ((exp_q.size() != 0 || bus.req_valid) && i < max_cycles) begin
         tick();
         i++;
      end
      check("drain_model_empty", exp_q.size(), 0);
      check("drain_out_valid_low", bus.out_valid, 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_in_ready"},   bus.in_ready, 1);
      check({tag, "_out_valid"},  bus.out_valid, 0);
      check({tag, "_out_flit"},   bus.out_flit, 0);
      check({tag, "_req_valid"},  bus.req_valid, 0);
      check({tag, "_req_dir"},    bus.req_dir, DIR_LOCAL);
      check({tag, "_release"},    bus.release_o, 0);
      check({tag, "_err_drop"},   bus.err_drop, 0);
      check({tag, "_table_addr"}, bus.table_addr, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int len;
      int dest;
      bus.in_valid  = 1'b0;
      bus.in_flit   = '0;
      bus.grant     = 1'b0;
      bus.out_ready = 1'b0;
      in_pkt        = 0;

      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst_n = 1'b1;
      tick();

      // Single-flit packet id=4 -> dest=5: request EAST at cycle 3, data at cycle 4.
      bus.in_valid = 1'b1;
      bus.in_flit  = mk_flit(1, 1, 5, 16'hA001);
      tick();
      bus.in_valid = 1'b0;
      check("t1_c1_req_valid", bus.req_valid, 0);
      check("t1_c1_table_addr", bus.table_addr, 5);
      tick();
      check("t1_c2_req_valid", bus.req_valid, 0);
      tick();
      check("t1_c3_req_valid", bus.req_valid, 1);
      check("t1_c3_req_dir", bus.req_dir, DIR_EAST);
      force_grant = 1;
      tick();
      force_grant = 0;
      check("t1_c4_out_valid", bus.out_valid, 1);
      check("t1_c4_out_flit", bus.out_flit, mk_flit(1, 1, 5, 16'hA001));
      check("t1_c4_release", bus.release_o, 1);
      tick();
      check("t1_c5_out_valid", bus.out_valid, 0);
      check("t1_c5_req_valid", bus.req_valid, 0);

      // Three-flit packet to node 1 (NORTH); grant withheld for five cycles.
      offer(mk_flit(1, 0, 1, 16'hB000));
      offer(mk_flit(0, 0, 1, 16'hB001));
      offer(mk_flit(0, 1, 1, 16'hB002));
      wait_req(20);
      repeat (5) begin
         check("t2_req_held", bus.req_valid, 1);
         check("t2_req_dir_north", bus.req_dir, DIR_NORTH);
         tick();
      end
      force_grant = 1;
      tick();
      force_grant = 0;
      wait_drain(50);

      // Backpressure: out_ready low, six flits offered, only four fit.
      auto_grant = 1;
      ready_cmd  = 0;
      for (int k = 0; k < 4; k++) offer(mk_flit(k == 0, 0, 7, 16'h3000 + 16'(k)));
      bus.in_valid = 1'b1;
      bus.in_flit  = mk_flit(0, 0, 7, 16'h3004);
      repeat (6) begin
         tick();
         check("t3_full_in_ready", bus.in_ready, 0);
      end
      check("t3_accepted_four", exp_q.size(), 4);
      ready_cmd = 1;
      tick();
      ready_cmd = 0;
      check("t3_after_pop_in_ready", bus.in_ready, 1);
      tick();
      check("t3_fifth_taken_full", bus.in_ready, 0);
      bus.in_flit = mk_flit(0, 1, 7, 16'h3005);
      ready_cmd = 1;
      offer(mk_flit(0, 1, 7, 16'h3005));
      wait_drain(100);

      // Stray body flit at the head while idle is dropped; the next head routes normally.
      bus.in_valid = 1'b1;
      bus.in_flit  = mk_flit(0, 0, 2, 16'hDEAD);
      tick();
      bus.in_valid = 1'b0;
      check("t4_err_drop_pulse", bus.err_drop, 1);
      tick();
      check("t4_err_drop_single", bus.err_drop, 0);
      check("t4_fifo_empty", bus.table_addr, 0);
      offer(mk_flit(1, 1, 3, 16'hC0DE));
      wait_drain(50);

      // Asynchronous reset while the second flit of a packet is being offered.
      offer(mk_flit(1, 0, 8, 16'h5000));
      bus.in_valid = 1'b1;
      bus.in_flit  = mk_flit(0, 0, 8, 16'h5001);
      #2;
      rst_n        = 1'b0;
      bus.in_valid = 1'b0;
      exp_q.delete();
      dir_q.delete();
      in_pkt = 0;
      #1;
      check_reset_outputs("t5_in_reset");
      tick();
      rst_n = 1'b1;
      tick();
      check_reset_outputs("t5_after_release");
      tick();
      check("t5_still_idle", bus.req_valid, 0);

      // Randomized traffic: packets of 1..4 flits, random destinations, stray body flits.
      rand_ready = 1;
      for (int p = 0; p < 40; p++) begin
         if ($urandom_range(0, 5) == 0)
            offer(mk_flit(0, $urandom_range(0, 1), $urandom_range(0, 8), 16'($urandom)));
         len  = $urandom_range(1, 4);
         dest = $urandom_range(0, 8);
         for (int i = 0; i < len; i++) begin
            offer(mk_flit(i == 0, i == len - 1, dest, 16'($urandom)));
            repeat ($urandom_range(0, 2)) tick();
         end
      end
      rand_ready = 0;
      ready_cmd  = 1;
      wait_drain(2000);
      check("final_dir_queue_empty", dir_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
